multi_clk_divider: RTL and testbench

MULTI_CLK_DIVIDER -- requirements
Module: multi_clk_divider

---
 rtl/multi_clk_divider.sv | 117 +++++++++++
 tb/tb_multi_clk_divider.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_clk_divider.sv
// Bank of independent programmable clock dividers with shadowed configuration.
// Divisor/mode updates are staged and committed at a terminal count so output periods never glitch.
module multi_clk_divider #(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = 26,
  parameter int unsigned DEFAULT_DIV = 62_499_999
) (
  input  logic                                     clk_in,
  input  logic                                     rst_n,
  input  logic [NUM_CH-1:0]                        ch_en,
  input  logic                                     cfg_wr,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]                         cfg_div,
  input  logic                                     cfg_mode,
  output logic                                     cfg_ready,
  output logic [NUM_CH-1:0]                        clk_out,
  output logic [NUM_CH-1:0]                        tick
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

  logic [1:0]        rst_pipe;
  logic              rst_sync_n;
  logic [NUM_CH-1:0] pending;

  // Reset asserts asynchronously but releases two edges later, in step with clk_in.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_sync_n = rst_pipe[1];

  // Out-of-range channel indices never match, so cfg_ready stays low for them.
  always_comb begin
    cfg_ready = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = ~pending[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act_div;
    logic [CNT_W-1:0] sh_div;
    logic             act_mode;
    logic             sh_mode;
    logic             pend;
    logic             clk_q;
    logic             tick_q;
    logic             hit;
    logic             term;
    logic             next_mode;

    assign hit       = cfg_wr && cfg_ready && (cfg_ch == CH_W'(g));
    assign term      = ch_en[g] && (cnt == act_div);
    assign next_mode = pend ? sh_mode : act_mode;

    always_ff @(posedge clk_in or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
        cnt      <= '0;
        act_div  <= DEF_DIV;
        sh_div   <= DEF_DIV;
        act_mode <= 1'b0;
        sh_mode  <= 1'b0;
        pend     <= 1'b0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        // A write is only taken while nothing is pending, so staging and commit never collide.
        if (hit) begin
          sh_div  <= cfg_div;
          sh_mode <= cfg_mode;
          pend    <= 1'b1;
        end else if (pend && (term || !ch_en[g])) begin
          act_div  <= sh_div;
          act_mode <= sh_mode;
          pend     <= 1'b0;
        end

        if (!ch_en[g]) begin
          cnt    <= '0;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
        end else if (term) begin
          cnt    <= '0;
          tick_q <= 1'b1;
          // Leaving pulse mode for toggle mode restarts the toggle from a low level.
          if (next_mode) begin
            clk_q <= 1'b1;
          end else if (act_mode) begin
            clk_q <= 1'b0;
          end else begin
            clk_q <= ~clk_q;
          end
        end else begin
          cnt    <= cnt + CNT_W'(1);
          tick_q <= 1'b0;
          if (act_mode) begin
            clk_q <= 1'b0;
          end
        end
      end
    end

    assign pending[g] = pend;
    assign clk_out[g] = clk_q;
    assign tick[g]    = tick_q;
  end

endmodule

// File: tb/tb_multi_clk_divider.sv
// Directed bench for multi_clk_divider: a reset/free-run vector table plus
// hand-written sequences for shadowed updates, disable, out-of-range writes and async reset.
module tb_multi_clk_divider;

  localparam int NUM_CH = 5;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 3;

  typedef struct {
    logic [NUM_CH-1:0] ch_en;
    logic              wr;
    logic [CH_W-1:0]   ch;
    logic [CNT_W-1:0]  div;
    logic              mode;
    logic              exp_ready;
    logic [NUM_CH-1:0] exp_clk;
    logic [NUM_CH-1:0] exp_tick;
  } vec_t;

  logic              clk_in;
  logic              rst_n;
  logic [NUM_CH-1:0] ch_en;
  logic              cfg_wr;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_mode;
  logic              cfg_ready;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  int   n_compared;
  int   n_mismatched;
  vec_t vectors[14];

  multi_clk_divider #(
    .NUM_CH(NUM_CH),
    .CNT_W(CNT_W),
    .DEFAULT_DIV(3)
  ) dut (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .ch_en(ch_en),
    .cfg_wr(cfg_wr),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .cfg_mode(cfg_mode),
    .cfg_ready(cfg_ready),
    .clk_out(clk_out),
    .tick(tick)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic step_cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    ch_en    = v.ch_en;
    cfg_wr   = v.wr;
    cfg_ch   = v.ch;
    cfg_div  = v.div;
    cfg_mode = v.mode;
  endtask

  // Free-running behaviour from the cycle after reset release, all channels at divisor 3.
  task automatic runTable(input string tag);
    for (int k = 0; k < 14; k++) begin
      applyStimulus(vectors[k]);
      #1;
      checkOutput($sformatf("%s_ready_%0d", tag, k), 32'(cfg_ready), 32'(vectors[k].exp_ready));
      step_cycle();
      checkOutput($sformatf("%s_clk_%0d", tag, k), 32'(clk_out), 32'(vectors[k].exp_clk));
      checkOutput($sformatf("%s_tick_%0d", tag, k), 32'(tick), 32'(vectors[k].exp_tick));
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;

    // Edges 1-2 are swallowed by the reset synchroniser; counting starts on edge 3.
    vectors[0]  = '{5'h1F, 1'b0, 3'd0, 8'd0, 1'b0, 1'b1, 5'h00, 5'h00};
    vectors[1]  = '{5'h1F, 1'b0, 3'd1, 8'd0, 1'b0, 1'b1, 5'h00, 5'h00};
    vectors[2]  = '{5'h1F, 1'b0, 3'd2, 8'd0, 1'b0, 1'b1, 5'h00, 5'h00};
    vectors[3]  = '{5'h1F, 1'b0, 3'd3, 8'd0, 1'b0, 1'b1, 5'h00, 5'h00};
    vectors[4]  = '{5'h1F, 1'b0, 3'd4, 8'd0, 1'b0, 1'b1, 5'h00, 5'h00};
    vectors[5]  = '{5'h1F, 1'b0, 3'd0, 8'd0, 1'b0, 1'b1, 5'h1F, 5'h1F};
    vectors[6]  = '{5'h1F, 1'b0, 3'd1, 8'd0, 1'b0, 1'b1, 5'h1F, 5'h00};
    vectors[7]  = '{5'h1F, 1'b0, 3'd2, 8'd0, 1'b0, 1'b1, 5'h1F, 5'h00};
    vectors[8]  = '{5'h1F, 1'b0, 3'd3, 8'd0, 1'b0, 1'b1, 5'h1F, 5'h00};
    vectors[9]  = '{5'h1F, 1'b0, 3'd4, 8'd0, 1'b0, 1'b1, 5'h00, 5'h1F};
    vectors[10] = '{5'h1F, 1'b0, 3'd0, 8'd0, 1'b0, 1'b1, 5'h00, 5'h00};
    vectors[11] = '{5'h1F, 1'b0, 3'd1, 8'd0, 1'b0, 1'b1, 5'h00, 5'h00};
    vectors[12] = '{5'h1F, 1'b0, 3'd2, 8'd0, 1'b0, 1'b1, 5'h00, 5'h00};
    vectors[13] = '{5'h1F, 1'b0, 3'd0, 8'd0, 1'b0, 1'b1, 5'h1F, 5'h1F};

    rst_n    = 1'b1;
    ch_en    = 5'h1F;
    cfg_wr   = 1'b0;
    cfg_ch   = 3'd0;
    cfg_div  = 8'd0;
    cfg_mode = 1'b0;
    #2;
    rst_n = 1'b0;
    step_cycle();
    step_cycle();
    checkOutput("rst_clk", 32'(clk_out), 32'd0);
    checkOutput("rst_tick", 32'(tick), 32'd0);
    checkOutput("rst_ready", 32'(cfg_ready), 32'd1);
    rst_n = 1'b1;
    runTable("run");

    // ch1 -> div 0, pulse: staged until ch1's terminal count three edges later.
    cfg_wr = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd0; cfg_mode = 1'b1;
    #1;
    checkOutput("b_ready_before", 32'(cfg_ready), 32'd1);
    step_cycle();
    cfg_wr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("b_ready_wait_%0d", k), 32'(cfg_ready), 32'd0);
      checkOutput($sformatf("b_tick1_wait_%0d", k), 32'(tick[1]), 32'd0);
      checkOutput($sformatf("b_clk1_wait_%0d", k), 32'(clk_out[1]), 32'd1);
      step_cycle();
    end
    checkOutput("b_ready_after", 32'(cfg_ready), 32'd1);
    checkOutput("b_tick1_tc", 32'(tick[1]), 32'd1);
    checkOutput("b_clk1_tc", 32'(clk_out[1]), 32'd1);
    checkOutput("b_tick0_tc", 32'(tick[0]), 32'd1);
    checkOutput("b_clk0_tc", 32'(clk_out[0]), 32'd0);

    // ch2: first write div 1 toggle accepted, second write blocked while pending.
    cfg_wr = 1'b1; cfg_ch = 3'd2; cfg_div = 8'd1; cfg_mode = 1'b0;
    #1;
    checkOutput("c_ready_first", 32'(cfg_ready), 32'd1);
    step_cycle();
    checkOutput("c_tick1_a", 32'(tick[1]), 32'd1);
    checkOutput("c_clk1_a", 32'(clk_out[1]), 32'd1);
    cfg_div = 8'd6; cfg_mode = 1'b1;
    #1;
    checkOutput("c_ready_second", 32'(cfg_ready), 32'd0);
    step_cycle();
    checkOutput("c_tick1_b", 32'(tick[1]), 32'd1);
    cfg_wr = 1'b0;
    step_cycle();
    checkOutput("c_tick1_c", 32'(tick[1]), 32'd1);
    checkOutput("c_ready_wait", 32'(cfg_ready), 32'd0);
    step_cycle();
    checkOutput("c_ready_after", 32'(cfg_ready), 32'd1);
    checkOutput("c_tick2_tc", 32'(tick[2]), 32'd1);
    checkOutput("c_clk2_tc", 32'(clk_out[2]), 32'd1);
    step_cycle();
    checkOutput("c_tick2_p1", 32'(tick[2]), 32'd0);
    checkOutput("c_clk2_p1", 32'(clk_out[2]), 32'd1);
    step_cycle();
    checkOutput("c_tick2_p2", 32'(tick[2]), 32'd1);
    checkOutput("c_clk2_p2", 32'(clk_out[2]), 32'd0);
    step_cycle();
    checkOutput("c_tick2_p3", 32'(tick[2]), 32'd0);
    step_cycle();
    checkOutput("c_tick2_p4", 32'(tick[2]), 32'd1);
    checkOutput("c_clk2_p4", 32'(clk_out[2]), 32'd1);

    // Write aimed at channel index NUM_CH must not touch any channel.
    cfg_wr = 1'b1; cfg_ch = 3'd5; cfg_div = 8'd2; cfg_mode = 1'b0;
    step_cycle();
    cfg_wr = 1'b0;
    step_cycle();
    step_cycle();
    checkOutput("d_tick0_mid", 32'(tick[0]), 32'd0);
    checkOutput("d_tick3_mid", 32'(tick[3]), 32'd0);
    checkOutput("d_tick2_mid", 32'(tick[2]), 32'd0);
    checkOutput("d_tick1_mid", 32'(tick[1]), 32'd1);
    step_cycle();
    checkOutput("d_tick_tc", 32'(tick), 32'h1F);
    for (int c = 0; c < NUM_CH; c++) begin
      cfg_ch = CH_W'(c);
      #1;
      checkOutput($sformatf("d_ready_ch%0d", c), 32'(cfg_ready), 32'd1);
    end

    // ch3 disabled mid-period, then reprogrammed to div 5 and re-enabled.
    ch_en = 5'b10111;
    step_cycle();
    checkOutput("e_clk3_off", 32'(clk_out[3]), 32'd0);
    checkOutput("e_tick3_off", 32'(tick[3]), 32'd0);
    cfg_wr = 1'b1; cfg_ch = 3'd3; cfg_div = 8'd5; cfg_mode = 1'b0;
    #1;
    checkOutput("e_ready_before", 32'(cfg_ready), 32'd1);
    step_cycle();
    cfg_wr = 1'b0;
    #1;
    checkOutput("e_ready_pending", 32'(cfg_ready), 32'd0);
    step_cycle();
    checkOutput("e_ready_applied", 32'(cfg_ready), 32'd1);
    ch_en = 5'h1F;
    for (int k = 1; k <= 18; k++) begin
      step_cycle();
      checkOutput($sformatf("e_tick3_%0d", k), 32'(tick[3]), 32'((k % 6) == 0));
      checkOutput($sformatf("e_clk3_%0d", k), 32'(clk_out[3]), 32'(((k / 6) % 2) == 1));
    end

    // Async reset with a write to ch0 still pending.
    cfg_wr = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd7; cfg_mode = 1'b1;
    step_cycle();
    cfg_wr = 1'b0;
    #1;
    checkOutput("f_ready_pending", 32'(cfg_ready), 32'd0);
    checkOutput("f_tick1_pre", 32'(tick[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("f_clk_async", 32'(clk_out), 32'd0);
    checkOutput("f_tick_async", 32'(tick), 32'd0);
    checkOutput("f_ready_async", 32'(cfg_ready), 32'd1);
    step_cycle();
    step_cycle();
    checkOutput("f_tick_hold", 32'(tick), 32'd0);
    rst_n = 1'b1;
    runTable("rerun");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
